// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_pkg                                                                   |
// | Shared encodings for the HI/LO multiply/divide unit.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mips_pkg;

  localparam int MD_DATA_W = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_shift_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_shift_core                                                              |
// | Accumulator with one radix-2 shift-add / restoring shift-subtract step.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module md_shift_core #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_is_div,
  input  logic [DATA_W-1:0]     i_load_val,
  input  logic [DATA_W-1:0]     i_operand,
  output logic [2*DATA_W-1:0]   o_acc
);

  localparam int ACC_W = 2*DATA_W + 1;

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_shl;
  logic [ACC_W-1:0]  w_mul_nxt;
  logic [ACC_W-1:0]  w_div_nxt;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W+1:0] w_diff;

  always_comb begin
    // Multiply: conditionally add into the upper half, then shift the pair right
    w_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, i_operand};
    if (r_acc[0])
      w_mul_nxt = {1'b0, w_sum, r_acc[DATA_W-1:1]};
    else
      w_mul_nxt = {2'b00, r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1:1]};

    // Divide: shift left, trial-subtract the divisor from the remainder field
    w_shl  = r_acc << 1;
    w_diff = {1'b0, w_shl[ACC_W-1:DATA_W]} - {2'b00, i_operand};
    if (!w_diff[DATA_W+1])
      w_div_nxt = {w_diff[DATA_W:0], w_shl[DATA_W-1:1], 1'b1};
    else
      w_div_nxt = w_shl;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_acc <= '0;
    else if (i_load)
      r_acc <= {{(DATA_W+1){1'b0}}, i_load_val};
    else if (i_step)
      r_acc <= i_is_div ? w_div_nxt : w_mul_nxt;
  end

  assign o_acc = r_acc[2*DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_div_unit                                                              |
// | Iterative MIPS32 MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W,
  parameter int ITER   = MD_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_e,
  input  logic [1:0]        op_e,
  input  logic [DATA_W-1:0] src_a_e,
  input  logic [DATA_W-1:0] src_b_e,
  input  logic              mthi_wb,
  input  logic              mtlo_wb,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mf_read_d,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              md_stall,
  output logic              div_by_zero
);

  md_state_e r_state;
  md_state_e w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_div;
  logic                r_q_neg;
  logic                r_rem_neg;
  logic                r_dz;
  logic                r_div_by_zero;
  logic [DATA_W-1:0]   r_b_mag;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic                w_signed;
  logic                w_op_div;
  logic                w_accept;
  logic                w_calc;
  logic                w_fix;
  logic                w_abort;
  logic                w_last;
  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic [2*DATA_W-1:0] w_acc;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  logic [DATA_W-1:0]   w_fix_hi;
  logic [DATA_W-1:0]   w_fix_lo;

  assign w_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign w_op_div = (op_e == MD_DIV)  || (op_e == MD_DIVU);
  assign w_a_mag  = (w_signed && src_a_e[DATA_W-1]) ? -src_a_e : src_a_e;
  assign w_b_mag  = (w_signed && src_b_e[DATA_W-1]) ? -src_b_e : src_b_e;

  assign w_accept = (r_state == IDLE) && start_e;
  assign w_calc   = (r_state == CALC);
  assign w_fix    = (r_state == FIX);
  assign w_abort  = w_calc && (mthi_wb || mtlo_wb);
  assign w_last   = (r_cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_e) w_state_nxt = CALC;
      CALC: begin
        if (w_abort)     w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = FIX;
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sign flags are forced low for unsigned ops so FIX needs no op decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_q_neg   <= 1'b0;
      r_rem_neg <= 1'b0;
      r_dz      <= 1'b0;
      r_b_mag   <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_is_div  <= w_op_div;
      r_q_neg   <= w_signed && (src_a_e[DATA_W-1] ^ src_b_e[DATA_W-1]);
      r_rem_neg <= w_signed && src_a_e[DATA_W-1];
      r_dz      <= (src_b_e == '0);
      r_b_mag   <= w_b_mag;
    end else if (w_calc) begin
      r_cnt     <= r_cnt + 1'b1;
    end
  end

  md_shift_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_step     (w_calc),
    .i_is_div   (r_is_div),
    .i_load_val (w_a_mag),
    .i_operand  (r_b_mag),
    .o_acc      (w_acc)
  );

  assign w_prod_fix = r_q_neg   ? -w_acc : w_acc;
  assign w_quo_fix  = r_q_neg   ? -w_acc[DATA_W-1:0] : w_acc[DATA_W-1:0];
  assign w_rem_fix  = r_rem_neg ? -w_acc[2*DATA_W-1:DATA_W] : w_acc[2*DATA_W-1:DATA_W];

  // A zero divisor leaves |a| in the remainder field; its sign fix restores a
  always_comb begin
    w_fix_hi = w_prod_fix[2*DATA_W-1:DATA_W];
    w_fix_lo = w_prod_fix[DATA_W-1:0];
    if (r_is_div) begin
      w_fix_hi = w_rem_fix;
      w_fix_lo = r_dz ? '1 : w_quo_fix;
    end
  end

  // A same-edge MTHI/MTLO takes priority over the FIX result for its register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi          <= '0;
      r_lo          <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      if (w_fix) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
      if (mthi_wb) r_hi <= wb_data;
      if (mtlo_wb) r_lo <= wb_data;

      if (w_accept)
        r_div_by_zero <= 1'b0;
      else if (w_fix && r_is_div)
        r_div_by_zero <= r_dz;
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = (r_state != IDLE);
  assign md_stall    = busy && (mf_read_d || start_e);
  assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mult_div_unit                                                           |
// | Directed self-checking bench for mult_div_unit.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_e;
  logic [1:0]  op_e;
  logic [31:0] src_a_e;
  logic [31:0] src_b_e;
  logic        mthi_wb;
  logic        mtlo_wb;
  logic [31:0] wb_data;
  logic        mf_read_d;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall;
  logic        div_by_zero;

  int n_tests;
  int n_fail;

  mult_div_unit #(
    .DATA_W (32),
    .ITER   (32),
    .CNT_W  (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_e     (start_e),
    .op_e        (op_e),
    .src_a_e     (src_a_e),
    .src_b_e     (src_b_e),
    .mthi_wb     (mthi_wb),
    .mtlo_wb     (mtlo_wb),
    .wb_data     (wb_data),
    .mf_read_d   (mf_read_d),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .md_stall    (md_stall),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_e    = op;
    src_a_e = a;
    src_b_e = b;
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
  endtask

  // Edges after accept until busy falls; 33 expected (E1..E33)
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'd33);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b);
    wait_done({tag, "_lat"});
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start_e   = 1'b0;
    op_e      = MD_MULT;
    src_a_e   = '0;
    src_b_e   = '0;
    mthi_wb   = 1'b0;
    mtlo_wb   = 1'b0;
    wb_data   = '0;
    mf_read_d = 1'b0;
    tick();
    tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    chk("rst_stall", 64'(md_stall), 64'd0);
    rst_n = 1'b1;

    // MULT -3 * 5, with busy timing around the accept edge
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy_e0", 64'(busy), 64'd1);
    wait_done("mult_lat");
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_wrap",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu",      MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
    chk("divu_dz", 64'(div_by_zero), 64'd0);

    // Divide by zero, then the next accept clears the flag
    run_op("divu_z", MD_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    chk("divu_z_dz", 64'(div_by_zero), 64'd1);
    issue(MD_MULTU, 32'd3, 32'd4);
    chk("dz_clr", 64'(div_by_zero), 64'd0);
    wait_done("mulu34_lat");
    chk("mulu34_lo", 64'(lo), 64'd12);
    run_op("div_z_neg", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    chk("div_z_neg_dz", 64'(div_by_zero), 64'd1);

    // Stall: mf_read_d from cycle 5, start_e held during busy must not re-accept
    issue(MD_MULT, 32'd6, 32'hFFFF_FFF9);
    for (int i = 0; i < 4; i++) tick();
    mf_read_d = 1'b1;
    start_e   = 1'b1;
    op_e      = MD_MULTU;
    src_a_e   = 32'd1;
    src_b_e   = 32'd1;
    #1;
    chk("stall_calc", 64'(md_stall), 64'd1);
    for (int i = 0; i < 28; i++) tick();
    chk("stall_fix", 64'(md_stall), 64'd1);
    chk("busy_fix", 64'(busy), 64'd1);
    tick();
    chk("stall_idle", 64'(md_stall), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("stall_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("stall_lo", 64'(lo), 64'hFFFF_FFD6);
    start_e   = 1'b0;
    mf_read_d = 1'b0;

    // MTLO at cycle 10 of a DIV aborts it; HI keeps its old value
    issue(MD_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    mtlo_wb = 1'b1;
    wb_data = 32'hA5A5_A5A5;
    tick();
    mtlo_wb = 1'b0;
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_lo", 64'(lo), 64'hA5A5_A5A5);
    chk("mtlo_hi", 64'(hi), 64'hFFFF_FFFF);

    // MTHI on the FIX edge overrides HI only
    issue(MD_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 32; i++) tick();
    mthi_wb = 1'b1;
    wb_data = 32'h5A5A_0000;
    tick();
    mthi_wb = 1'b0;
    chk("mthi_fix_hi", 64'(hi), 64'h5A5A_0000);
    chk("mthi_fix_lo", 64'(lo), 64'd14);
    chk("mthi_fix_busy", 64'(busy), 64'd0);

    // MTHI together with an accept in IDLE
    mthi_wb = 1'b1;
    wb_data = 32'h1111_2222;
    issue(MD_MULTU, 32'd2, 32'd3);
    mthi_wb = 1'b0;
    chk("mt_acc_hi", 64'(hi), 64'h1111_2222);
    chk("mt_acc_lo", 64'(lo), 64'd14);
    chk("mt_acc_busy", 64'(busy), 64'd1);
    wait_done("mt_acc_lat");
    chk("mt_acc_hi2", 64'(hi), 64'd0);
    chk("mt_acc_lo2", 64'(lo), 64'd6);

    // Reset at cycle 20 of a MULT, then a fresh start
    issue(MD_MULT, 32'd3, 32'd3);
    for (int i = 0; i < 19; i++) tick();
    rst_n     = 1'b0;
    mf_read_d = 1'b1;
    tick();
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_stall", 64'(md_stall), 64'd0);
    rst_n     = 1'b1;
    mf_read_d = 1'b0;
    issue(MD_MULTU, 32'd5, 32'd5);
    chk("post_rst_busy", 64'(busy), 64'd1);
    wait_done("post_rst_lat");
    chk("post_rst_lo", 64'(lo), 64'd25);
    chk("post_rst_hi", 64'(hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS32 pipeline.
- Executes MULT/MULTU/DIV/DIVU issued from Execute and owns the architectural HI/LO registers.
- Takes MTHI/MTLO writes from Writeback and produces the HI/LO values the pipeline reads for MFHI/MFLO.
- Raises md_stall toward the hazard logic so that Decode/Fetch/Execute hold while an operation is in flight.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- ITER, 32, compute iterations per operation; must equal DATA_W.
- CNT_W, 6, iteration counter width; must be at least clog2(ITER+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start_e  in  1  mult/div instruction valid in Execute.
- op_e  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a_e  in  DATA_W  rs operand (multiplicand / dividend).
- src_b_e  in  DATA_W  rt operand (multiplier / divisor).
- mthi_wb  in  1  MTHI retiring in Writeback.
- mtlo_wb  in  1  MTLO retiring in Writeback.
- wb_data  in  DATA_W  MTHI/MTLO source value.
- mf_read_d  in  1  MFHI or MFLO in Decode.
- hi  out  DATA_W  architectural HI.
- lo  out  DATA_W  architectural LO.
- busy  out  1  operation in flight.
- md_stall  out  1  stall request to hazard logic.
- div_by_zero  out  1  last division had a zero divisor.

Behaviour:
- Reset: clk edge with rst_n=0 sets hi=0, lo=0, busy=0, div_by_zero=0, counter=0, state=IDLE. Reset mid-operation abandons the operation; HI/LO still go to 0.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC on start_e=1.
  - CALC -> FIX when counter reaches ITER-1.
  - FIX -> IDLE unconditionally.
- Accept (edge E0, state IDLE, start_e=1):
  - Latch operand magnitudes: absolute values for signed ops, raw values for unsigned.
  - Latch sign flags: product/quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clear counter; busy=1.
- CALC, one iteration per cycle, counter increments each cycle:
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; the remainder occupies the upper half and the quotient the lower half.
- FIX (edge E33):
  - Multiply: negate the 64-bit product if signed and the sign flag is set; HI = product[63:32], LO = product[31:0].
  - Divide: negate quotient/remainder per their sign flags; LO = quotient, HI = remainder.
  - busy drops after E33. Total latency is 34 edges from accept to IDLE; new HI/LO are visible in the cycle following E33.
- Divide by zero (divisor == 0 at accept):
  - Operation still runs the full 34 cycles.
  - Result: LO = all ones, HI = original dividend (unsigned value as given), div_by_zero=1.
  - div_by_zero holds until the next accepted start.
- start_e while busy: ignored. The hazard logic must hold the instruction in Execute.
- md_stall = busy & (mf_read_d | start_e). It is combinational and is 0 in IDLE.
- MTHI/MTLO in IDLE: writes the named register at the edge; the other register is unchanged.
- MTHI/MTLO while busy: aborts the in-flight operation (state -> IDLE, busy=0), then writes the named register; the other register keeps its pre-operation value.
- MTHI/MTLO on the FIX edge: the FIX result is written, then the mt write overrides its own register. Example: mthi_wb on E33 gives HI = wb_data and LO = the computed value.
- MTHI/MTLO and start_e together in IDLE: the mt write is applied and the operation is accepted; the later FIX overwrites both registers.
- Arithmetic notes:
  - The accumulator is 2*DATA_W+1 bits to absorb the divide borrow.
  - MULT of 0x80000000 by 0x80000000 gives HI=0x40000000, LO=0.
  - DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).

Decomposition:
- Shared package mips_pkg:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU.
  - FSM state encoding IDLE/CALC/FIX.
  - DATA_W default.
- One natural sub-module: md_shift_core, the 65-bit accumulator plus the add/subtract-and-shift step, selected by a mul/div select. The FSM, sign handling and HI/LO registers stay in the top level.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 34 edges HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high for exactly 34 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234, div_by_zero=1. The next MULTU clears div_by_zero at its accept edge.
- Start MULT, assert mf_read_d on cycle 5 -> md_stall=1 through the FIX cycle and 0 the cycle after. start_e held during busy is not re-accepted.
- MTLO 0xA5A5A5A5 at cycle 10 of a DIV -> busy=0 next cycle, LO=0xA5A5A5A5, HI unchanged. MTHI coincident with FIX -> HI=wb_data, LO=quotient.
- rst_n=0 for one edge at cycle 20 of a MULT -> hi=lo=0, busy=0, md_stall=0, state IDLE; a new start is accepted on the next edge.
